bus_trace: RTL and testbench
============================

Name: bus_trace

Overview:
- Parametrised successor to the single-window 6502 bus sniffing done at top level.
- Records synchronised 6502 bus cycles (address, data, RW, SYNC) into a circular trace RAM.
- NUM_TRIG maskable address comparators, each with an access-type mode, trigger the capture; pre/post-trigger depth is programmable.
- Front-panel logic (cpu_control/uiControl) reads back the captured history oldest-first for display while the CPU is halted.

Parameters:
ADDR_W, 16, captured address width (16 now, 20 once Ahigh is live)
DATA_W, 8, captured data width
DEPTH_LOG2, 4, trace depth = 2**DEPTH_LOG2 entries
NUM_TRIG, 2, number of trigger comparators

Ports:
CLK25MHZ  in  1  system clock
rst_n  in  1  asynchronous active-low reset
phi2  in  1  PHI2, already synchronised to CLK25MHZ
a  in  ADDR_W  synchronised address bus
d  in  DATA_W  synchronised data bus
rw  in  1  synchronised RW (1 = read)
sync  in  1  synchronised SYNC (opcode fetch)
arm  in  1  single-cycle pulse: clear and start capture
abort  in  1  single-cycle pulse: stop capture, keep data
force_trig  in  1  single-cycle pulse: trigger immediately
trig_en  in  NUM_TRIG  per-comparator enable
trig_addr  in  NUM_TRIG*ADDR_W  compare values, comparator i at [i*ADDR_W +: ADDR_W]
trig_mask  in  NUM_TRIG*ADDR_W  1 = bit compared
trig_mode  in  NUM_TRIG*2  0 any access, 1 read, 2 write, 3 opcode fetch (sync=1)
post_count  in  DEPTH_LOG2  cycles captured after the trigger cycle
rd_idx  in  DEPTH_LOG2  0 = oldest valid entry
rd_en  in  1  read strobe
rd_data  out  ADDR_W+DATA_W+2  {sync, rw, a, d}
rd_valid  out  1  rd_data update strobe
state  out  2  0 IDLE, 1 PRE, 2 POST, 3 DONE
triggered  out  1  trigger has fired since the last arm
trig_hit  out  NUM_TRIG  comparator(s) that caused the trigger
fill  out  DEPTH_LOG2+1  valid entries, saturates at 2**DEPTH_LOG2

Behaviour:
- Reset: state IDLE; all outputs 0; write pointer 0; fill 0. RAM contents are undefined and need no reset.
- Capture point:
  - Registered edge detect of phi2; a bus cycle is sampled on the cycle phi2 falls (1->0).
  - A capture is one RAM write of {sync, rw, a, d} at the write pointer; the pointer then increments mod DEPTH and fill increments, saturating.
- Comparator i hits when all hold on the capture cycle:
  - trig_en[i];
  - ((a ^ trig_addr_i) & trig_mask_i) == 0;
  - mode matches (1: rw=1, 2: rw=0, 3: sync=1).
- IDLE: no captures. arm -> PRE; clears fill, pointer, triggered and trig_hit.
- PRE: every capture is stored. If any comparator hits on that capture, or force_trig is set that cycle:
  - the triggering cycle is stored;
  - triggered=1; trig_hit latched (all zero for force_trig);
  - remaining = post_count;
  - next state POST, or DONE if post_count==0.
- POST: each capture stores and decrements remaining; the capture that takes remaining to 0 -> DONE. Comparators are ignored.
- DONE: no captures; holds until arm.
- post_count is sampled at the trigger; values above DEPTH-1 cannot occur given the width. When post_count = DEPTH-1, the pre-trigger history is fully overwritten except the trigger entry.
- Priority, same cycle:
  - abort > arm > trigger/capture.
  - abort -> IDLE from any state; data, fill and triggered are kept.
  - arm in any state restarts (same as from IDLE); a capture coincident with arm is discarded.
  - force_trig outside PRE is ignored.
- Readout:
  - Oldest entry is at physical index (wptr - fill) mod DEPTH; rd_idx is added to it.
  - rd_en -> rd_data and rd_valid one cycle later (registered RAM read); rd_valid is a one-cycle pulse.
  - rd_idx >= fill returns all zeros.
  - Reads are legal in any state; during PRE/POST data reflects RAM at the read cycle.
- Asynchronous reset mid-capture returns to IDLE with fill=0.

Decomposition:
- Shared package bus_trace_pkg:
  - state encodings ST_IDLE/ST_PRE/ST_POST/ST_DONE;
  - mode encodings TM_ANY/TM_READ/TM_WRITE/TM_FETCH;
  - entry-width function.
- Sub-module trace_ram: simple dual-port RAM, 1 write, 1 registered read port; infers block RAM.
- Comparators are a generate loop inside bus_trace.

Test Plan (DEPTH_LOG2=4, NUM_TRIG=2, ADDR_W=16):
- Reset mid-POST -> state=0, fill=0, triggered=0, rd_valid=0 immediately; the next arm works normally.
- arm, 20 read cycles at a=0x0200+n, comparator 0 = 0x0213 mask 0xFFFF mode 0, post_count=3:
  - hit on n=19, then 3 more cycles -> DONE, fill=16, trig_hit=01;
  - rd_idx 0 -> a=0x0207; rd_idx 15 -> a=0x0216.
- Comparator 1 = 0xFF00 mask 0xFF00 mode 2:
  - read of 0xFF10 -> no trigger;
  - write d=0x5A to 0xFF10 -> trig_hit=10; entry holds rw=0, d=0x5A.
- Mode 3 on 0x8000: data read of 0x8000 with sync=0 ignored; fetch with sync=1 triggers.
- force_trig after 5 captures, post_count=0 -> DONE next, fill=6, trig_hit=00; rd_idx 6 -> 0.
- abort in PRE after 4 captures -> IDLE, fill=4 retained. Simultaneous arm+abort -> IDLE. arm in DONE -> PRE with fill=0.

Source files
------------

// File: rtl/bus_trace_pkg.sv
// Shared encodings for the 6502 bus trace: FSM states, trigger modes, entry width.
// No logic of its own.
package bus_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_POST = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] TM_ANY   = 2'd0;
  localparam logic [1:0] TM_READ  = 2'd1;
  localparam logic [1:0] TM_WRITE = 2'd2;
  localparam logic [1:0] TM_FETCH = 2'd3;

  // One trace entry is {sync, rw, a, d}.
  function automatic int entry_w(input int addr_w, input int data_w);
    return addr_w + data_w + 2;
  endfunction

endpackage

// File: rtl/bus_trace_ram.sv
// Simple dual-port trace RAM: one write port, one registered read port (1-cycle latency).
// No backpressure; contents are not reset.
module trace_ram #(
  parameter int AW = 4,
  parameter int W  = 26
) (
  input  logic          CLK25MHZ,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [2**AW];

  always_ff @(posedge CLK25MHZ) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/bus_trace.sv
// Circular 6502 bus-cycle trace with NUM_TRIG maskable comparators and programmable post-trigger depth.
// Captures on the cycle phi2 falls; readout is one cycle after rd_en; no backpressure.
module bus_trace
  import bus_trace_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 4,
  parameter int NUM_TRIG   = 2
) (
  input  logic                         CLK25MHZ,
  input  logic                         rst_n,
  input  logic                         phi2,
  input  logic [ADDR_W-1:0]            a,
  input  logic [DATA_W-1:0]            d,
  input  logic                         rw,
  input  logic                         sync,
  input  logic                         arm,
  input  logic                         abort,
  input  logic                         force_trig,
  input  logic [NUM_TRIG-1:0]          trig_en,
  input  logic [NUM_TRIG*ADDR_W-1:0]   trig_addr,
  input  logic [NUM_TRIG*ADDR_W-1:0]   trig_mask,
  input  logic [NUM_TRIG*2-1:0]        trig_mode,
  input  logic [DEPTH_LOG2-1:0]        post_count,
  input  logic [DEPTH_LOG2-1:0]        rd_idx,
  input  logic                         rd_en,
  output logic [ADDR_W+DATA_W+1:0]     rd_data,
  output logic                         rd_valid,
  output logic [1:0]                   state,
  output logic                         triggered,
  output logic [NUM_TRIG-1:0]          trig_hit,
  output logic [DEPTH_LOG2:0]          fill
);

  localparam int EW = entry_w(ADDR_W, DATA_W);
  localparam logic [DEPTH_LOG2:0] FILL_MAX = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);

  state_t                st;
  logic                  phi2_q;
  logic                  capture;
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] remaining;
  logic [NUM_TRIG-1:0]   hit;
  logic                  trig_now;
  logic                  we;
  logic [DEPTH_LOG2-1:0] raddr;
  logic [EW-1:0]         ram_q;
  logic                  rd_zero;

  assign capture = phi2_q & ~phi2;

  for (genvar i = 0; i < NUM_TRIG; i++) begin : g_cmp
    logic [ADDR_W-1:0] ta;
    logic [ADDR_W-1:0] tm;
    logic [1:0]        md;
    logic              mode_ok;

    assign ta = trig_addr[i*ADDR_W +: ADDR_W];
    assign tm = trig_mask[i*ADDR_W +: ADDR_W];
    assign md = trig_mode[i*2 +: 2];

    always_comb begin
      mode_ok = 1'b1;
      case (md)
        TM_READ:  mode_ok = rw;
        TM_WRITE: mode_ok = ~rw;
        TM_FETCH: mode_ok = sync;
        default:  mode_ok = 1'b1;
      endcase
    end

    assign hit[i] = trig_en[i] && (((a ^ ta) & tm) == '0) && mode_ok;
  end

  assign trig_now = force_trig | (capture & (|hit));

  // A forced trigger stores the current bus even off a capture edge, so the
  // trigger point is always present in the trace.
  assign we = ~abort & ~arm &
              (((st == ST_PRE) & (capture | force_trig)) | ((st == ST_POST) & capture));

  assign raddr = wptr - fill[DEPTH_LOG2-1:0] + rd_idx;

  trace_ram #(.AW(DEPTH_LOG2), .W(EW)) u_ram (
    .CLK25MHZ (CLK25MHZ),
    .we       (we),
    .waddr    (wptr),
    .wdata    ({sync, rw, a, d}),
    .re       (rd_en),
    .raddr    (raddr),
    .rdata    (ram_q)
  );

  always_ff @(posedge CLK25MHZ or negedge rst_n) begin
    if (!rst_n) begin
      st        <= ST_IDLE;
      phi2_q    <= 1'b0;
      wptr      <= '0;
      fill      <= '0;
      remaining <= '0;
      triggered <= 1'b0;
      trig_hit  <= '0;
    end else begin
      phi2_q <= phi2;
      if (abort) begin
        st <= ST_IDLE;
      end else if (arm) begin
        st        <= ST_PRE;
        wptr      <= '0;
        fill      <= '0;
        triggered <= 1'b0;
        trig_hit  <= '0;
      end else begin
        if (we) begin
          wptr <= wptr + DEPTH_LOG2'(1);
          if (fill != FILL_MAX) fill <= fill + (DEPTH_LOG2+1)'(1);
        end
        case (st)
          ST_PRE: begin
            if (trig_now) begin
              triggered <= 1'b1;
              trig_hit  <= force_trig ? '0 : hit;
              remaining <= post_count;
              st        <= (post_count == '0) ? ST_DONE : ST_POST;
            end
          end
          ST_POST: begin
            if (capture) begin
              remaining <= remaining - DEPTH_LOG2'(1);
              if (remaining == DEPTH_LOG2'(1)) st <= ST_DONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // rd_zero also masks the unreset RAM output so rd_data reads 0 out of reset.
  always_ff @(posedge CLK25MHZ or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_zero  <= 1'b1;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_zero <= ({1'b0, rd_idx} >= fill);
    end
  end

  assign rd_data = rd_zero ? '0 : ram_q;
  assign state   = st;

endmodule

// File: tb/tb_bus_trace.sv
// Directed-vector bench for bus_trace (ADDR_W=16, DATA_W=8, DEPTH_LOG2=4, NUM_TRIG=2).
module tb_bus_trace;

  logic        CLK25MHZ = 1'b0;
  logic        rst_n = 1'b0;
  logic        phi2 = 1'b0;
  logic [15:0] a = '0;
  logic [7:0]  d = '0;
  logic        rw = 1'b1;
  logic        sync = 1'b0;
  logic        arm = 1'b0;
  logic        abort = 1'b0;
  logic        force_trig = 1'b0;
  logic [1:0]  trig_en = '0;
  logic [31:0] trig_addr = '0;
  logic [31:0] trig_mask = '0;
  logic [3:0]  trig_mode = '0;
  logic [3:0]  post_count = '0;
  logic [3:0]  rd_idx = '0;
  logic        rd_en = 1'b0;
  logic [25:0] rd_data;
  logic        rd_valid;
  logic [1:0]  state;
  logic        triggered;
  logic [1:0]  trig_hit;
  logic [4:0]  fill;

  int n_cmp = 0;
  int n_err = 0;

  always #20 CLK25MHZ = ~CLK25MHZ;

  bus_trace #(.ADDR_W(16), .DATA_W(8), .DEPTH_LOG2(4), .NUM_TRIG(2)) dut (
    .CLK25MHZ   (CLK25MHZ),
    .rst_n      (rst_n),
    .phi2       (phi2),
    .a          (a),
    .d          (d),
    .rw         (rw),
    .sync       (sync),
    .arm        (arm),
    .abort      (abort),
    .force_trig (force_trig),
    .trig_en    (trig_en),
    .trig_addr  (trig_addr),
    .trig_mask  (trig_mask),
    .trig_mode  (trig_mode),
    .post_count (post_count),
    .rd_idx     (rd_idx),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .state      (state),
    .triggered  (triggered),
    .trig_hit   (trig_hit),
    .fill       (fill)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One 6502 bus cycle; the capture edge lands in the phi2-low half.
  task automatic bus(input logic [15:0] addr, input logic [7:0] dat,
                     input logic r, input logic s, input logic frc);
    a = addr; d = dat; rw = r; sync = s; phi2 = 1'b1;
    @(negedge CLK25MHZ);
    phi2 = 1'b0; force_trig = frc;
    @(negedge CLK25MHZ);
    force_trig = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    @(negedge CLK25MHZ);
    arm = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    @(negedge CLK25MHZ);
    abort = 1'b0;
  endtask

  task automatic rd(input logic [3:0] idx);
    rd_idx = idx; rd_en = 1'b1;
    @(negedge CLK25MHZ);
    rd_en = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge CLK25MHZ);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_fill", 32'(fill), 32'd0);
    chk("rst_triggered", 32'(triggered), 32'd0);
    chk("rst_trig_hit", 32'(trig_hit), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    rst_n = 1'b1;
    @(negedge CLK25MHZ);

    // Comparator 0 exact match on 0x0213, any access, 3 post cycles
    trig_en = 2'b01; trig_addr = {16'h0000, 16'h0213};
    trig_mask = {16'h0000, 16'hFFFF}; trig_mode = 4'b0000; post_count = 4'd3;
    do_arm();
    chk("arm_state", 32'(state), 32'd1);
    for (int n = 0; n < 19; n++) bus(16'h0200 + 16'(n), 8'(n), 1'b1, 1'b0, 1'b0);
    chk("pre_no_hit", 32'(state), 32'd1);
    bus(16'h0213, 8'h13, 1'b1, 1'b0, 1'b0);
    chk("hit_post", 32'(state), 32'd2);
    chk("hit_triggered", 32'(triggered), 32'd1);
    for (int n = 20; n < 23; n++) bus(16'h0200 + 16'(n), 8'(n), 1'b1, 1'b0, 1'b0);
    chk("post_done", 32'(state), 32'd3);
    chk("post_fill", 32'(fill), 32'd16);
    chk("post_trig_hit", 32'(trig_hit), 32'd1);
    rd(4'd0);
    chk("rd_valid_pulse", 32'(rd_valid), 32'd1);
    chk("rd0_addr", 32'(rd_data[23:8]), 32'h0207);
    @(negedge CLK25MHZ);
    chk("rd_valid_drop", 32'(rd_valid), 32'd0);
    rd(4'd15);
    chk("rd15_addr", 32'(rd_data[23:8]), 32'h0216);
    bus(16'h0300, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("done_holds", 32'(state), 32'd3);
    rd(4'd15);
    chk("done_no_capture", 32'(rd_data[23:8]), 32'h0216);

    // Comparator 1: page 0xFFxx, writes only
    trig_en = 2'b10; trig_addr = {16'hFF00, 16'h0000};
    trig_mask = {16'hFF00, 16'h0000}; trig_mode = 4'b1000; post_count = 4'd0;
    do_arm();
    chk("rearm_fill", 32'(fill), 32'd0);
    chk("rearm_triggered", 32'(triggered), 32'd0);
    chk("rearm_trig_hit", 32'(trig_hit), 32'd0);
    bus(16'hFF10, 8'h11, 1'b1, 1'b0, 1'b0);
    chk("wr_mode_read_ignored", 32'(state), 32'd1);
    bus(16'hFF10, 8'h5A, 1'b0, 1'b0, 1'b0);
    chk("wr_mode_done", 32'(state), 32'd3);
    chk("wr_mode_trig_hit", 32'(trig_hit), 32'd2);
    chk("wr_mode_fill", 32'(fill), 32'd2);
    rd(4'd1);
    chk("wr_entry", 32'(rd_data), 32'h0FF105A);
    rd(4'd0);
    chk("rd_entry", 32'(rd_data), 32'h1FF1011);

    // Comparator 0 opcode-fetch mode
    trig_en = 2'b01; trig_addr = {16'h0000, 16'h8000};
    trig_mask = {16'h0000, 16'hFFFF}; trig_mode = 4'b0011; post_count = 4'd0;
    do_arm();
    bus(16'h8000, 8'hEA, 1'b1, 1'b0, 1'b0);
    chk("fetch_data_ignored", 32'(state), 32'd1);
    bus(16'h8000, 8'hEA, 1'b1, 1'b1, 1'b0);
    chk("fetch_done", 32'(state), 32'd3);
    chk("fetch_trig_hit", 32'(trig_hit), 32'd1);
    rd(4'd1);
    chk("fetch_entry", 32'(rd_data), 32'h3800_0EA);

    // Forced trigger after 5 captures
    trig_en = 2'b00; post_count = 4'd0;
    do_arm();
    for (int n = 0; n < 5; n++) bus(16'h1000 + 16'(n), 8'h00, 1'b1, 1'b0, 1'b0);
    bus(16'h1005, 8'h00, 1'b1, 1'b0, 1'b1);
    chk("force_done", 32'(state), 32'd3);
    chk("force_fill", 32'(fill), 32'd6);
    chk("force_trig_hit", 32'(trig_hit), 32'd0);
    chk("force_triggered", 32'(triggered), 32'd1);
    rd(4'd6);
    chk("rd_past_fill", 32'(rd_data), 32'd0);
    rd(4'd5);
    chk("force_entry_addr", 32'(rd_data[23:8]), 32'h1005);

    // Abort and arm priorities
    do_arm();
    for (int n = 0; n < 4; n++) bus(16'h2000 + 16'(n), 8'h00, 1'b1, 1'b0, 1'b0);
    do_abort();
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_fill", 32'(fill), 32'd4);
    chk("abort_triggered", 32'(triggered), 32'd0);
    arm = 1'b1; abort = 1'b1;
    @(negedge CLK25MHZ);
    arm = 1'b0; abort = 1'b0;
    chk("arm_abort_state", 32'(state), 32'd0);
    chk("arm_abort_fill", 32'(fill), 32'd4);
    bus(16'h2100, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("idle_no_capture", 32'(fill), 32'd4);
    do_arm();
    bus(16'h2200, 8'h00, 1'b1, 1'b0, 1'b1);
    chk("to_done_fill", 32'(fill), 32'd1);
    do_arm();
    chk("arm_in_done_state", 32'(state), 32'd1);
    chk("arm_in_done_fill", 32'(fill), 32'd0);

    // Asynchronous reset mid-POST
    post_count = 4'd3;
    bus(16'h3000, 8'h00, 1'b1, 1'b0, 1'b1);
    bus(16'h3001, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("mid_post_state", 32'(state), 32'd2);
    rd(4'd0);
    #5 rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_fill", 32'(fill), 32'd0);
    chk("arst_triggered", 32'(triggered), 32'd0);
    chk("arst_rd_valid", 32'(rd_valid), 32'd0);
    @(negedge CLK25MHZ);
    rst_n = 1'b1;
    @(negedge CLK25MHZ);
    do_arm();
    bus(16'h4000, 8'h77, 1'b1, 1'b0, 1'b0);
    chk("post_rst_state", 32'(state), 32'd1);
    chk("post_rst_fill", 32'(fill), 32'd1);
    rd(4'd0);
    chk("post_rst_entry", 32'(rd_data), 32'h1400077);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
